// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: strobe bit positions,
// occupancy encoding of the stage buffer and the default-sized payload record.
package pipe_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_WB_W       = 2;

  localparam int MEM_WR_BIT = 0;
  localparam int MEM_RD_BIT = 1;

  // Occupancy of the stage buffer; ST_TWO is only reachable with a skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [DEF_WB_W-1:0]       wb;
    logic [1:0]                m;
    logic [DEF_DATA_W-1:0]     alu_result;
    logic [DEF_DATA_W-1:0]     store_data;
    logic [DEF_REG_ADDR_W-1:0] rd;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage buffer with an optional skid entry and a synchronous
// flush that drops every held and incoming word.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int         W          = 8,
  parameter bit         SKID       = 1'b1,
  parameter logic [W-1:0] FLUSH_MASK = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output occ_state_t   state
);

  // Handshake: a word moves on a rising edge when valid and ready are both high
  // in the preceding cycle; valid never depends on ready, and flush overrides both.
  occ_state_t   state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         valid_int, accept, emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !emit)      state_d = ST_TWO;
          else if (!accept && emit) state_d = ST_EMPTY;
        end
        ST_TWO:   if (emit) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // With a skid entry in_ready is a pure decode of the state register, so it
  // never combinationally follows out_ready.
  always_comb begin
    valid_int = (state_q != ST_EMPTY);
    if (SKID) in_ready = (state_q != ST_TWO);
    else      in_ready = (state_q == ST_EMPTY) || out_ready;
    accept   = in_valid && in_ready;
    emit     = valid_int && out_ready;
    out_data = main_q;
    state    = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= main_q & ~FLUSH_MASK;
      skid_q <= skid_q & ~FLUSH_MASK;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) main_q <= in_data;
        ST_ONE: begin
          if (accept && emit) main_q <= in_data;
          else if (accept)    skid_q <= in_data;
        end
        ST_TWO:   if (emit) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline boundary register: buffers the ALU-stage result with
// back-pressure and flush, then decodes the memory strobes with bubble gating.
module ex_mem_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter bit SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WB_W-1:0]       ctrl_wb_in,
  input  logic [1:0]            ctrl_m_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WB_W-1:0]       ctrl_wb_out,
  output logic                  mem_write_out,
  output logic                  mem_read_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [REG_ADDR_W-1:0] rd_out
);

  // Field order matches ex_mem_payload_t: {wb, m, alu_result, store_data, rd}.
  localparam int PW     = WB_W + 2 + 2 * DATA_W + REG_ADDR_W;
  localparam int CTRL_W = WB_W + 2;
  localparam logic [PW-1:0] CTRL_MASK = {{CTRL_W{1'b1}}, {(PW - CTRL_W){1'b0}}};

  logic [PW-1:0] in_pl, out_pl;
  logic [WB_W-1:0] wb_q;
  logic [1:0]      m_q;
  occ_state_t      buf_state;

  assign in_pl = {ctrl_wb_in, ctrl_m_in, alu_result_in, store_data_in, rd_in};

  // Flush clears only the control fields; address and data keep their last value.
  pipe_skid_buf #(
    .W          (PW),
    .SKID       (SKID),
    .FLUSH_MASK (CTRL_MASK)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_ready (out_ready),
    .out_data  (out_pl),
    .state     (buf_state)
  );

  always_comb begin
    out_valid      = (buf_state != ST_EMPTY);
    wb_q           = out_pl[PW-1 -: WB_W];
    m_q            = out_pl[PW-WB_W-1 -: 2];
    alu_result_out = out_pl[2*DATA_W+REG_ADDR_W-1 -: DATA_W];
    store_data_out = out_pl[DATA_W+REG_ADDR_W-1 -: DATA_W];
    rd_out         = out_pl[REG_ADDR_W-1:0];
    // A bubble must never write memory or the register file.
    ctrl_wb_out    = out_valid ? wb_q : '0;
    mem_write_out  = out_valid && m_q[MEM_WR_BIT];
    mem_read_out   = out_valid && m_q[MEM_RD_BIT];
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
Parametrised EX/MEM pipeline boundary register with valid/ready handshake, stall absorption via an optional skid entry, and synchronous flush. It sits between the ALU stage and the data-memory stage. It carries the WB control field, the mem-write and mem-read strobes, the ALU result, the store data and the destination register address. It replaces the free-running stage latch so that memory back-pressure and branch flushes can be handled without losing or duplicating instructions.

Parameters:
DATA_W, 32, width of the ALU result and store-data paths
REG_ADDR_W, 5, width of the destination register address
WB_W, 2, width of the write-back control field
SKID, 1, 1 = two-entry skid (registered in_ready); 0 = single entry (combinational in_ready)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  EX stage presents an instruction
in_ready  out  1  stage can accept this cycle
ctrl_wb_in  in  WB_W  write-back control
ctrl_m_in  in  2  bit0 = mem write, bit1 = mem read
alu_result_in  in  DATA_W  ALU result / memory address
store_data_in  in  DATA_W  store data (forwarded rt value)
rd_in  in  REG_ADDR_W  destination register
out_valid  out  1  MEM stage has a valid instruction
out_ready  in  1  MEM stage consumes this cycle
ctrl_wb_out  out  WB_W  write-back control
mem_write_out  out  1  data-memory write strobe
mem_read_out  out  1  data-memory read strobe
alu_result_out  out  DATA_W
store_data_out  out  DATA_W
rd_out  out  REG_ADDR_W

Behaviour:
- Reset (async, rst=1): main and skid entries invalid and all payload registers 0. Outputs: out_valid=0, all data/control outputs 0, in_ready=1.
- Transfer rules: accept when in_valid & in_ready; emit when out_valid & out_ready.
- Latency: one cycle. Data accepted at edge N appears on the outputs after edge N when the stage was empty or drained at N.
- Bubble safety: ctrl_wb_out, mem_write_out and mem_read_out are 0 whenever out_valid=0. Data outputs hold their last value.
- SKID=1 state machine (occupancy counter 0..2):
  - EMPTY: accept -> ONE.
  - ONE: accept & emit -> ONE (main reloads). Accept only -> TWO (incoming word goes to the skid entry). Emit only -> EMPTY.
  - TWO: emit -> ONE (skid moves to main). No emit -> TWO.
  - in_ready = (state != TWO), registered and independent of out_ready. Any in_valid while in_ready=0 is ignored.
- SKID=0: single entry. in_ready = ~out_valid | out_ready (combinational). Accept & emit in the same cycle reloads the entry.
- Ordering: strictly FIFO. The skid entry is never presented ahead of the main entry.
- Flush: at the next edge, state becomes EMPTY and all control payload bits are cleared. The same-cycle input is discarded even when in_valid & in_ready. Flush takes priority over accept and emit. in_ready=1 in the following cycle.
- Flush with rst both asserted: rst dominates. The result is the same reset state.
- While out_valid=1 and out_ready=0, all outputs hold stable (no glitching of the strobes).

Decomposition:
- Shared package pipe_pkg holds:
  - constants MEM_WR_BIT=0 and MEM_RD_BIT=1
  - a packed struct ex_mem_payload_t {wb, m, alu_result, store_data, rd}, sized from the package defaults
- One natural sub-module: pipe_skid_buf, a generic payload-width valid/ready skid buffer with flush. ex_mem_stage_reg instantiates it, then decodes the mem strobes and applies the bubble gating.

Test Plan:
- Reset mid-stream: load alu_result_in=0x0000_1234 and assert rst asynchronously between edges -> out_valid=0, mem_read_out=0 and alu_result_out=0 immediately, before the next edge; in_ready=1.
- Streaming: out_ready=1, issue 8 back-to-back ops with rd_in=1..8 and ctrl_m_in=2'b10 -> out_valid from cycle 1; rd_out=1..8 on consecutive cycles, each with mem_read_out=1; no gaps.
- Back-pressure: hold out_ready=0 while sending A (alu 0xA) then B (0xB) -> in_ready drops to 0 after B is accepted, and C is ignored. Release out_ready -> outputs A, then B, then C after re-presentation. Order preserved, no duplicates.
- Flush while full: state TWO with store op A (ctrl_m_in=2'b01) held; assert flush with in_valid=1 -> next cycle out_valid=0, mem_write_out=0, in_ready=1; neither A, B nor the incoming op ever appears.
- Bubble gating: in_valid=0 for 3 cycles after a store -> mem_write_out=0 and ctrl_wb_out=0 in each of those cycles, while alu_result_out holds its last value.
- SKID=0 build: out_ready=0 with the entry full -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 combinationally, and the entry reloads at the edge.
